muldiv_sequencer: RTL and testbench

Multi-cycle unsigned MULT/DIV engine that owns the HI/LO register pair for the MIPS core. It replaces single-event multiply and divide with an iterative shift-add multiplier and a restoring divider, sequenced by a small FSM. The control unit issues work through a valid/ready handshake and stalls on busy. Results return through hi/lo with a one-cycle done pulse. Opcodes match the ALU control encoding.

---
 rtl/muldiv_sequencer_pkg.sv | 25 ++
 rtl/muldiv_sequencer_if.sv | 36 +++
 rtl/muldiv_sequencer_datapath.sv | 93 +++++++++
 rtl/muldiv_sequencer.sv | 130 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine of the MIPS core.
// Holds the ALU control opcodes, the engine FSM encoding and the default operand width.
package muldiv_sequencer_pkg;

    localparam int WIDTH_DEF = 32;

    // ALU control encoding; the engine only acts on MULT and DIV.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_MULT = 4'b1000,
        ALU_DIV  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit <-> mult/div engine bundle: start handshake, operands,
// MTHI/MTLO write port, and busy/done/HI/LO/status outputs.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_srcA;
    logic [WIDTH-1:0] alu_srcB;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic             illegal_op;

    // Control unit side.
    modport master (
        output start_valid, alu_control, alu_srcA, alu_srcB,
        output hi_we, lo_we, wr_data,
        input  start_ready, busy, done, hi, lo,
        input  div_by_zero, illegal_op
    );

    // Engine side.
    modport slave (
        input  start_valid, alu_control, alu_srcA, alu_srcB,
        input  hi_we, lo_we, wr_data,
        output start_ready, busy, done, hi, lo,
        output div_by_zero, illegal_op
    );
endinterface

// File: rtl/muldiv_sequencer_datapath.sv
// Iterative working registers for shift-add multiply and restoring divide.
// Ports: load/load_div/a_in/b_in seed an op, step/step_div advance one bit; nxt_hi/nxt_lo give the post-step value.
module muldiv_sequencer_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_div,
    input  logic             step,
    input  logic             step_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    // acc_hi: accumulator upper half / remainder.
    // acc_lo: accumulator lower half / dividend shifting into quotient.
    // opb:    multiplicand / divisor.  mplr: multiplier.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;

    logic [WIDTH:0]   add_a;
    logic [WIDTH+1:0] add_r;
    logic [WIDTH:0]   mul_sum;
    logic             ge;

    always_comb begin
        add_a   = '0;
        add_r   = '0;
        mul_sum = '0;
        ge      = 1'b0;
        nxt_hi  = acc_hi_q;
        nxt_lo  = acc_lo_q;

        if (step_div) begin
            add_a = {acc_hi_q, acc_lo_q[WIDTH-1]};
        end else begin
            add_a = {1'b0, acc_hi_q};
        end

        // Single adder: XOR/carry-in turns it into a subtractor for divide;
        // the extra top bit is the borrow.
        add_r = {1'b0, add_a}
              + ({2'b00, opb_q} ^ {(WIDTH+2){step_div}})
              + {{(WIDTH+1){1'b0}}, step_div};

        if (step_div) begin
            ge     = ~add_r[WIDTH+1];
            nxt_hi = ge ? add_r[WIDTH-1:0] : add_a[WIDTH-1:0];
            nxt_lo = {acc_lo_q[WIDTH-2:0], ge};
        end else begin
            mul_sum = mplr_q[0] ? add_r[WIDTH:0] : {1'b0, acc_hi_q};
            nxt_hi  = mul_sum[WIDTH:1];
            nxt_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        mplr_d   = mplr_q;
        if (load) begin
            acc_hi_d = '0;
            acc_lo_d = load_div ? a_in : '0;
            opb_d    = load_div ? b_in : a_in;
            mplr_d   = b_in;
        end else if (step) begin
            acc_hi_d = nxt_hi;
            acc_lo_d = nxt_lo;
            mplr_d   = mplr_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            mplr_q   <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            mplr_q   <= mplr_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULT/DIV engine owning HI/LO; FSM, iteration count, handshake.
// Ports: clk, rst (async high), bus (slave modport: start handshake, MTHI/MTLO, hi/lo/done/status).
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int         WIDTH   = WIDTH_DEF,
    parameter logic [3:0] OP_MULT = ALU_MULT,
    parameter logic [3:0] OP_DIV  = ALU_DIV
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic             last;
    logic             dp_load, dp_load_div, dp_step, dp_step_div;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    assign accept = bus.start_valid && (state_q == ST_IDLE);
    assign last   = (cnt_q == CW'(WIDTH-1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dbz_d       = dbz_q;
        ill_d       = 1'b0;
        dp_load     = 1'b0;
        dp_load_div = 1'b0;
        dp_step     = 1'b0;
        dp_step_div = (state_q == ST_DIV);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.hi_we) hi_d = bus.wr_data;
                if (bus.lo_we) lo_d = bus.wr_data;
                if (accept) begin
                    if (bus.alu_control == OP_MULT) begin
                        state_d = ST_MUL;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        dp_load = 1'b1;
                    end else if (bus.alu_control == OP_DIV) begin
                        if (bus.alu_srcB == '0) begin
                            // No iterations: report and finish immediately.
                            state_d = ST_DONE;
                            hi_d    = '0;
                            lo_d    = '0;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d     = ST_DIV;
                            cnt_d       = '0;
                            dbz_d       = 1'b0;
                            dp_load     = 1'b1;
                            dp_load_div = 1'b1;
                        end
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    // Final step result goes straight into HI/LO.
                    state_d = ST_DONE;
                    hi_d    = nxt_hi;
                    lo_d    = nxt_lo;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            ill_q   <= ill_d;
        end
    end

    muldiv_sequencer_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .load_div (dp_load_div),
        .step     (dp_step),
        .step_div (dp_step_div),
        .a_in     (bus.alu_srcA),
        .b_in     (bus.alu_srcB),
        .nxt_hi   (nxt_hi),
        .nxt_lo   (nxt_lo)
    );

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.illegal_op  = ill_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [3:0] OPM = 4'b1000;
    localparam logic [3:0] OPD = 4'b1001;

    typedef struct {
        bit          ill;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic        dbz;
        int          t0;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int neg_count = 0;
    int last_acc = 0;
    exp_t q[$];

    // Reference state: final model HI/LO, the value visible while busy, sticky flag.
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] vis_hi = '0, vis_lo = '0;
    logic m_dbz = 1'b0;

    // Monitor: pops an expectation for every done or illegal_op pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_count++;
            if (!rst && (bus.done || bus.illegal_op)) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_resp done=%b ill=%b hi=%h lo=%h required no response",
                             bus.done, bus.illegal_op, bus.hi, bus.lo);
                end else begin
                    e = q.pop_front();
                    if (bus.done !== !e.ill || bus.illegal_op !== e.ill ||
                        bus.hi !== e.hi || bus.lo !== e.lo ||
                        bus.div_by_zero !== e.dbz || (neg_count - e.t0) != e.lat) begin
                        miscompares++;
                        $display("FAIL resp got done=%b ill=%b hi=%h lo=%h dbz=%b lat=%0d required done=%b ill=%b hi=%h lo=%h dbz=%b lat=%0d",
                                 bus.done, bus.illegal_op, bus.hi, bus.lo, bus.div_by_zero,
                                 neg_count - e.t0, !e.ill, e.ill, e.hi, e.lo, e.dbz, e.lat);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic hw, input logic lw, input logic [W-1:0] wd);
        exp_t e;
        int waitc;
        logic [2*W-1:0] prod;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.alu_control = op;
        bus.alu_srcA    = a;
        bus.alu_srcB    = b;
        bus.hi_we       = hw;
        bus.lo_we       = lw;
        bus.wr_data     = wd;
        waitc = 0;
        while (!bus.start_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.start_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout ready=%b required 1", bus.start_ready);
            bus.start_valid = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            return;
        end
        @(posedge clk);
        last_acc = neg_count;
        if (hw) m_hi = wd;
        if (lw) m_lo = wd;
        vis_hi = m_hi;
        vis_lo = m_lo;
        e.ill = 1'b0;
        e.t0  = neg_count;
        e.lat = W + 1;
        if (op == OPM) begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            m_hi = prod[2*W-1:W];
            m_lo = prod[W-1:0];
            m_dbz = 1'b0;
        end else if (op == OPD) begin
            if (b == 0) begin
                m_hi = '0;
                m_lo = '0;
                m_dbz = 1'b1;
                e.lat = 1;
            end else begin
                m_hi = a % b;
                m_lo = a / b;
                m_dbz = 1'b0;
            end
        end else begin
            e.ill = 1'b1;
            e.lat = 1;
        end
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.dbz = m_dbz;
        q.push_back(e);
        #1;
        bus.start_valid = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // One-cycle MTHI/MTLO strobe; only takes effect if the engine is idle.
    task automatic write_reg(input logic hw, input logic lw, input logic [W-1:0] wd);
        logic rdy;
        @(negedge clk);
        bus.hi_we   = hw;
        bus.lo_we   = lw;
        bus.wr_data = wd;
        rdy = bus.start_ready;
        @(posedge clk);
        if (rdy) begin
            if (hw) m_hi = wd;
            if (lw) m_lo = wd;
            vis_hi = m_hi;
            vis_lo = m_lo;
        end
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        @(negedge clk);
        check(rdy ? "mt_hi" : "busy_hi_hold", bus.hi, rdy ? m_hi : vis_hi);
        check(rdy ? "mt_lo" : "busy_lo_hold", bus.lo, rdy ? m_lo : vis_lo);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.start_ready && n < 100);
        check("idle_wait_ready", {{(W-1){1'b0}}, bus.start_ready}, 1);
    endtask

    initial begin
        int t1;
        logic [3:0] op;
        logic [W-1:0] a, b;
        int k, n;

        bus.start_valid = 1'b0;
        bus.alu_control = '0;
        bus.alu_srcA    = '0;
        bus.alu_srcB    = '0;
        bus.hi_we       = 1'b0;
        bus.lo_we       = 1'b0;
        bus.wr_data     = '0;

        #1;
        check("rst_busy",  {{(W-1){1'b0}}, bus.busy}, 0);
        check("rst_ready", {{(W-1){1'b0}}, bus.start_ready}, 1);
        check("rst_hi",    bus.hi, 0);
        check("rst_lo",    bus.lo, 0);
        check("rst_flags", {{(W-3){1'b0}}, bus.done, bus.div_by_zero, bus.illegal_op}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Full-width multiply and back-to-back divides.
        issue(OPM, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        issue(OPD, 100, 7, 0, 0, 0);
        issue(OPD, 5, 9, 0, 0, 0);

        // Divide by zero, then a multiply clears the sticky flag.
        issue(OPD, 1234, 0, 0, 0, 0);
        issue(OPM, 3, 4, 0, 0, 0);

        // Queued request while busy, with a dropped mid-op MTLO.
        issue(OPM, 6, 7, 0, 0, 0);
        t1 = last_acc;
        write_reg(1'b0, 1'b1, 32'hDEAD);
        issue(OPD, 9, 3, 0, 0, 0);
        check("queued_accept_gap", last_acc - t1, W + 2);

        // Illegal opcode, then MTHI in idle.
        issue(4'b0000, 32'h11, 32'h22, 0, 0, 0);
        wait_idle();
        write_reg(1'b1, 1'b0, 32'hCAFEF00D);
        write_reg(1'b1, 1'b1, 32'h0BADBEEF);

        // Reset mid-multiply: partial result discarded, no done follows.
        issue(OPM, 32'h12345678, 32'h9ABCDEF1, 0, 0, 0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",  {{(W-1){1'b0}}, bus.busy}, 0);
        check("midrst_ready", {{(W-1){1'b0}}, bus.start_ready}, 1);
        check("midrst_hi",    bus.hi, 0);
        check("midrst_lo",    bus.lo, 0);
        q.delete();
        m_hi = '0;
        m_lo = '0;
        vis_hi = '0;
        vis_lo = '0;
        m_dbz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (k <= 3) op = OPM;
            else if (k <= 6) op = OPD;
            else if (k == 7) begin op = OPD; b = 0; end
            else if (k == 9) begin op = OPD; b = $urandom_range(1, 20); end
            else begin
                do op = 4'($urandom_range(0, 15)); while (op == OPM || op == OPD);
            end
            if (op == OPD && k != 7 && b == 0) b = 1;
            n = $urandom_range(0, 3);
            if (n == 0) begin
                wait_idle();
                write_reg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            if (n == 1)
                issue(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            else
                issue(op, a, b, 0, 0, 0);
            if (n == 2 && (op == OPM || (op == OPD && b != 0)))
                write_reg(1'($urandom_range(0, 1)), 1'b1, $urandom);
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
